// File: rtl/bblf_pkg.sv
// Shared types and default constants for the bang-bang loop filter.
package bblf_pkg;

  typedef enum logic [0:0] {ST_ACQ, ST_TRACK} bblf_state_e;

  // Default loop configuration
  localparam int unsigned DefOutW    = 10;
  localparam int unsigned DefCenter  = 512;
  localparam int unsigned DefIntW    = 16;
  localparam int unsigned DefIntFrac = 4;
  localparam int unsigned DefKpAcq   = 3;
  localparam int unsigned DefKiAcq   = 4;
  localparam int unsigned DefKpTrk   = 1;
  localparam int unsigned DefKiTrk   = 2;
  localparam int unsigned DefAcqCnt  = 64;

  // Lock detector thresholds
  localparam int unsigned LockN  = 16;
  localparam int unsigned RunMax = 4;

  // Decision sign encoding on pd_up
  localparam logic SIGN_UP = 1'b1;
  localparam logic SIGN_DN = 1'b0;

endpackage

// File: rtl/bb_loop_filter_if.sv
// Decision input / DCO word output bundle of the loop filter.
interface bb_loop_filter_if #(
  parameter int unsigned OUT_W = 10
);
  logic             pd_up;
  logic             pd_valid;
  logic             freeze;
  logic [OUT_W-1:0] dco_word;
  logic             word_valid;
  logic             acq;
  logic             lock;

  modport master (
    output pd_up, pd_valid, freeze,
    input  dco_word, word_valid, acq, lock
  );

  modport slave (
    input  pd_up, pd_valid, freeze,
    output dco_word, word_valid, acq, lock
  );
endinterface

// File: rtl/bblf_lock_det.sv
// Lock detector: flags steady alternation of accepted bang-bang decisions.
module bblf_lock_det import bblf_pkg::*; #(
  parameter int unsigned LOCK_N  = LockN,
  parameter int unsigned RUN_MAX = RunMax
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pd_up,
  input  logic accept,
  output logic lock
);
  localparam int unsigned AltW = $clog2(LOCK_N + 1);
  localparam int unsigned RunW = $clog2(RUN_MAX + 1);

  logic            seeded_q, prev_q, lock_q, lock_d;
  logic [AltW-1:0] alt_q, alt_d;
  logic [RunW-1:0] run_q, run_d;

  // Next alternation / run counts (saturating) and lock decision
  always_comb begin
    alt_d  = alt_q;
    run_d  = run_q;
    lock_d = lock_q;
    if (!seeded_q) begin
      // First decision only provides the reference sign
      alt_d = '0;
      run_d = RunW'(1);
    end else if (pd_up != prev_q) begin
      alt_d = (alt_q == AltW'(LOCK_N)) ? alt_q : alt_q + AltW'(1);
      run_d = RunW'(1);
    end else begin
      alt_d = '0;
      run_d = (run_q == RunW'(RUN_MAX)) ? run_q : run_q + RunW'(1);
    end
    if (alt_d == AltW'(LOCK_N)) begin
      lock_d = 1'b1;
    end else if (run_d == RunW'(RUN_MAX)) begin
      lock_d = 1'b0;
    end
  end

  // Detector state advances only on accepted decisions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seeded_q <= 1'b0;
      prev_q   <= 1'b0;
      alt_q    <= '0;
      run_q    <= '0;
      lock_q   <= 1'b0;
    end else if (accept) begin
      seeded_q <= 1'b1;
      prev_q   <= pd_up;
      alt_q    <= alt_d;
      run_q    <= run_d;
      lock_q   <= lock_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: rtl/bb_loop_filter.sv
// Two-gear PI loop filter turning bang-bang decisions into a DCO control word.
// Define BBLF_LOCK_DET_EN to build the lock detector; otherwise lock is tied low.
module bb_loop_filter import bblf_pkg::*; #(
  parameter int unsigned OUT_W    = DefOutW,
  parameter int unsigned CENTER   = DefCenter,
  parameter int unsigned INT_W    = DefIntW,
  parameter int unsigned INT_FRAC = DefIntFrac,
  parameter int unsigned KP_ACQ   = DefKpAcq,
  parameter int unsigned KI_ACQ   = DefKiAcq,
  parameter int unsigned KP_TRK   = DefKpTrk,
  parameter int unsigned KI_TRK   = DefKiTrk,
  parameter int unsigned ACQ_CNT  = DefAcqCnt
) (
  input logic              clk,
  input logic              rst_n,
  bb_loop_filter_if.slave  bus
);
  localparam int unsigned SumW  = INT_W + 1;
  localparam int unsigned CalcW = INT_W + 2;
  localparam int unsigned PropW = ((KP_ACQ > KP_TRK) ? KP_ACQ : KP_TRK) + 2;
  localparam int unsigned CntW  = $clog2(ACQ_CNT + 1);

  localparam logic signed [SumW-1:0]  IntMax  = SumW'((2 ** (INT_W - 1)) - 1);
  localparam logic signed [SumW-1:0]  IntMin  = SumW'(-(2 ** (INT_W - 1)));
  localparam logic signed [SumW-1:0]  StepAcq = SumW'(2 ** KI_ACQ);
  localparam logic signed [SumW-1:0]  StepTrk = SumW'(2 ** KI_TRK);
  localparam logic signed [PropW-1:0] PropAcq = PropW'(2 ** KP_ACQ);
  localparam logic signed [PropW-1:0] PropTrk = PropW'(2 ** KP_TRK);
  localparam logic signed [CalcW-1:0] OutMax  = CalcW'((2 ** OUT_W) - 1);
  localparam logic signed [CalcW-1:0] CenterW = CalcW'(CENTER);
  localparam logic [CntW-1:0]         CntLast = CntW'(ACQ_CNT - 1);

  bblf_state_e             state_q;
  logic [CntW-1:0]         cnt_q;
  logic                    acq_q;
  logic                    accept, in_acq, lock;
  logic signed [INT_W-1:0] int_q, int_d;
  logic signed [PropW-1:0] prop_q, prop_d;
  logic [OUT_W-1:0]        word_q, word_d;
  logic                    word_valid_q;
  logic signed [SumW-1:0]  step, int_sum;
  logic signed [CalcW-1:0] word_sum;

  // freeze has priority over a coincident strobe
  assign accept = bus.pd_valid & ~bus.freeze;
  assign in_acq = (state_q == ST_ACQ);

  // Next integrator, proportional term and clamped output word
  always_comb begin
    step    = in_acq ? StepAcq : StepTrk;
    int_sum = SumW'(int_q) + ((bus.pd_up == SIGN_UP) ? step : -step);
    if (int_sum > IntMax) begin
      int_d = IntMax[INT_W-1:0];
    end else if (int_sum < IntMin) begin
      int_d = IntMin[INT_W-1:0];
    end else begin
      int_d = int_sum[INT_W-1:0];
    end
    if (bus.pd_up == SIGN_UP) begin
      prop_d = in_acq ? PropAcq : PropTrk;
    end else begin
      prop_d = in_acq ? -PropAcq : -PropTrk;
    end
    word_sum = CenterW + CalcW'(int_d >>> INT_FRAC) + CalcW'(prop_d);
    if (word_sum[CalcW-1]) begin
      word_d = '0;
    end else if (word_sum > OutMax) begin
      word_d = OutMax[OUT_W-1:0];
    end else begin
      word_d = word_sum[OUT_W-1:0];
    end
  end

  // Loop state and output word update once per accepted decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q        <= '0;
      prop_q       <= '0;
      word_q       <= OUT_W'(CENTER);
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= accept;
      if (accept) begin
        int_q  <= int_d;
        prop_q <= prop_d;
        word_q <= word_d;
      end
    end
  end

  // Gear FSM: ACQ_CNT decisions in ACQ, then TRACK until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACQ;
      cnt_q   <= '0;
      acq_q   <= 1'b1;
    end else if (accept && state_q == ST_ACQ) begin
      if (cnt_q == CntLast) begin
        state_q <= ST_TRACK;
        acq_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

`ifdef BBLF_LOCK_DET_EN
  bblf_lock_det #(
    .LOCK_N  (LockN),
    .RUN_MAX (RunMax)
  ) u_lock_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .pd_up  (bus.pd_up),
    .accept (accept),
    .lock   (lock)
  );
`else
  assign lock = 1'b0;
`endif

  assign bus.dco_word   = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.acq        = acq_q;
  assign bus.lock       = lock;

endmodule
